// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// supported operand width range.
package adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Combinational full adder built from two half adders; the two partial carries
// can never both be set, so an OR merges them.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (x),
        .y (y),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule : full_adder

// File: rtl/half_adder.sv
// Single-bit half adder cell: sum is the XOR, carry the AND of the two inputs.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per cycle, LSB first,
// through a single full adder with a registered carry.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of supported range");
    end

    // Handshake: start is sampled only in IDLE or DONE; the edge that sees it
    // captures a/b/cin. done pulses for one cycle when sum/cout become valid,
    // and busy covers exactly the WIDTH bit-add cycles in between.
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               accept;
    logic               fa_s;
    logic               fa_c;

    full_adder u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                // Counter parks on the last index instead of wrapping.
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                accept = start;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_SHIFT;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: expected results come from plain
// (WIDTH+1)-bit addition and the WIDTH-cycle busy window.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(output logic [W-1:0] ra, output logic [W-1:0] rb, output logic rc);
        ra = W'($urandom_range(0, 2**W - 1));
        rb = W'($urandom_range(0, 2**W - 1));
        rc = 1'($urandom_range(0, 1));
    endtask

    // Presents operands with start for one accepting edge; returns in the
    // first busy cycle with start low.
    task automatic accept(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles (optionally pulsing start with junk operands at busy
    // cycle 'poke'), then checks the done cycle against ea+eb+ec.
    task automatic finish_op(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                             input string tag, input int poke);
        logic [W:0]   exp;
        logic [W-1:0] ja;
        logic [W-1:0] jb;
        logic         jc;
        int           n;
        exp = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({tag, "_done_while_busy"}, 32'(done), 32'd0);
            if (poke >= 0) begin
                if (n == poke) begin
                    rand_ops(ja, jb, jc);
                    a     = ja;
                    b     = jb;
                    cin   = jc;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            n++;
            step();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(W));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    endtask

    // One idle cycle after done: pulse gone, result held.
    task automatic idle_after(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec,
                              input string tag);
        logic [W:0] exp;
        exp = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
        step();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, "_cout_hold"}, 32'(cout), 32'(exp[W]));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] da [4];
        logic [W-1:0] db [4];
        logic         dc [4];

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed vectors.
        da[0] = 8'h00; db[0] = 8'h00; dc[0] = 1'b0;
        da[1] = 8'hFF; db[1] = 8'h01; dc[1] = 1'b0;
        da[2] = 8'hA5; db[2] = 8'h5A; dc[2] = 1'b1;
        da[3] = 8'd100; db[3] = 8'd27; dc[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            accept(da[i], db[i], dc[i]);
            finish_op(da[i], db[i], dc[i], $sformatf("dir%0d", i), -1);
            idle_after(da[i], db[i], dc[i], $sformatf("dir%0d", i));
        end

        // Randomized operands, variable idle gaps.
        for (int i = 0; i < 20; i++) begin
            rand_ops(ra, rb, rc);
            accept(ra, rb, rc);
            finish_op(ra, rb, rc, $sformatf("rnd%0d", i), -1);
            idle_after(ra, rb, rc, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) step();
        end

        // Start pulsed mid-operation is ignored.
        rand_ops(ra, rb, rc);
        accept(ra, rb, rc);
        finish_op(ra, rb, rc, "poke", 3);
        start = 1'b0;
        idle_after(ra, rb, rc, "poke");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("poke_no_extra_done", 32'(done), 32'd0);
        end

        // Start held across done: back-to-back operation.
        rand_ops(ra, rb, rc);
        a     = ra;
        b     = rb;
        cin   = rc;
        start = 1'b1;
        step();
        a   = 8'h0F;
        b   = 8'hF0;
        cin = 1'b0;
        finish_op(ra, rb, rc, "hold1", -1);
        step();
        start = 1'b0;
        finish_op(8'h0F, 8'hF0, 1'b0, "hold2", -1);
        idle_after(8'h0F, 8'hF0, 1'b0, "hold2");

        // Reset in the middle of an operation aborts it.
        rand_ops(ra, rb, rc);
        accept(ra | 8'h80, rb | 8'h80, rc);
        repeat (3) step();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Reset wins over start on the same edge.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h44;
        step();
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        chk("rst_vs_start_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();

        // Operation after the abort still works.
        accept(8'h80, 8'h80, 1'b1);
        finish_op(8'h80, 8'h80, 1'b1, "post_abort", -1);
        idle_after(8'h80, 8'h80, 1'b1, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
